// File: rtl/xentry_pkg.sv
// Shared types for the L2 controller: memory operation encoding and controller state.
package xentry_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        STORE   = 2'd1,
        CLFLUSH = 2'd2
    } memory_operation_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLUSH     = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } l2_ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = W'((int'(ptr) + i) % int'(N));
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/l2_arbitrated_cache_controller.sv
// L2 control FSM: round-robin port arbitration, hit/miss decode, writeback, fill and line flush.
module l2_arbitrated_cache_controller
    import xentry_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    input  memory_operation_e [NUM_PORTS-1:0]      req_type,
    output logic [NUM_PORTS-1:0]                   req_fulfilled,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
    output logic                                   memory_req_valid,
    output memory_operation_e                      memory_req_type,
    input  logic                                   memory_req_fulfilled,
    output logic [$clog2(WORDS_PER_LINE)-1:0]      beat_index,
    output logic                                   process_lru_counters,
    output logic                                   flush_mode,
    output logic                                   load_mode,
    output logic                                   set_selected_dirty_bit,
    output logic                                   clear_selected_dirty_bit,
    output logic                                   clear_selected_valid_bit,
    output logic                                   perform_write,
    output logic                                   finish_new_line_install,
    output logic                                   set_new_higher_memory_block_address,
    output logic                                   use_dirty_tag_for_higher_memory_block_address,
    input  logic                                   valid_block_match,
    input  logic                                   valid_dirty_bit
);

    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    l2_ctrl_state_e    state, state_d;
    logic [PORT_W-1:0] rr_ptr, rr_ptr_d;
    logic [PORT_W-1:0] grant_q, grant_q_d;
    logic [BEAT_W-1:0] beat, beat_d;

    logic [PORT_W-1:0] winner;
    logic              any_req;
    logic              last_beat;

    function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
        return PORT_W'((int'(p) + 1) % int'(NUM_PORTS));
    endfunction

    rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    assign beat_index = beat;
    assign last_beat  = memory_req_fulfilled && (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            beat    <= '0;
        end else begin
            state   <= state_d;
            rr_ptr  <= rr_ptr_d;
            grant_q <= grant_q_d;
            beat    <= beat_d;
        end
    end

    // Outputs are forced to their idle values while reset is held so nothing completes mid-abort.
    always_comb begin
        state_d   = state;
        rr_ptr_d  = rr_ptr;
        grant_q_d = grant_q;
        beat_d    = beat;
        grant_id  = grant_q;
        req_fulfilled            = '0;
        memory_req_valid         = 1'b0;
        memory_req_type          = LOAD;
        process_lru_counters     = 1'b0;
        flush_mode               = 1'b0;
        load_mode                = 1'b0;
        set_selected_dirty_bit   = 1'b0;
        clear_selected_dirty_bit = 1'b0;
        clear_selected_valid_bit = 1'b0;
        perform_write            = 1'b0;
        finish_new_line_install  = 1'b0;
        set_new_higher_memory_block_address           = 1'b0;
        use_dirty_tag_for_higher_memory_block_address = 1'b0;

        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    grant_id = rr_ptr;
                    if (any_req) begin
                        grant_id  = winner;
                        grant_q_d = winner;
                        rr_ptr_d  = winner;
                        case (req_type[winner])
                            LOAD, STORE: begin
                                if (valid_block_match) begin
                                    req_fulfilled[winner]  = 1'b1;
                                    process_lru_counters   = 1'b1;
                                    perform_write          = (req_type[winner] == STORE);
                                    set_selected_dirty_bit = (req_type[winner] == STORE);
                                    rr_ptr_d               = next_port(winner);
                                end else if (valid_dirty_bit) begin
                                    set_new_higher_memory_block_address           = 1'b1;
                                    use_dirty_tag_for_higher_memory_block_address = 1'b1;
                                    beat_d  = '0;
                                    state_d = ST_WRITEBACK;
                                end else begin
                                    set_new_higher_memory_block_address = 1'b1;
                                    beat_d  = '0;
                                    state_d = ST_ALLOCATE;
                                end
                            end
                            CLFLUSH: begin
                                if (valid_block_match && valid_dirty_bit) begin
                                    set_new_higher_memory_block_address = 1'b1;
                                    beat_d  = '0;
                                    state_d = ST_FLUSH;
                                end else begin
                                    clear_selected_valid_bit = valid_block_match;
                                    req_fulfilled[winner]    = 1'b1;
                                    rr_ptr_d                 = next_port(winner);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WRITEBACK, ST_FLUSH: begin
                    flush_mode       = 1'b1;
                    memory_req_valid = 1'b1;
                    memory_req_type  = STORE;
                    if (memory_req_fulfilled) beat_d = beat + BEAT_W'(1);
                    if (last_beat) begin
                        clear_selected_dirty_bit = 1'b1;
                        clear_selected_valid_bit = 1'b1;
                        beat_d = '0;
                        if (state == ST_WRITEBACK) begin
                            set_new_higher_memory_block_address = 1'b1;
                            state_d = ST_ALLOCATE;
                        end else begin
                            req_fulfilled[grant_q] = 1'b1;
                            rr_ptr_d = next_port(grant_q);
                            state_d  = ST_IDLE;
                        end
                    end
                end
                ST_ALLOCATE: begin
                    load_mode        = 1'b1;
                    memory_req_valid = 1'b1;
                    memory_req_type  = LOAD;
                    perform_write    = memory_req_fulfilled;
                    if (memory_req_fulfilled) beat_d = beat + BEAT_W'(1);
                    // rr_ptr left on the missing port so it re-wins and completes as a hit.
                    if (last_beat) begin
                        finish_new_line_install  = 1'b1;
                        clear_selected_dirty_bit = 1'b1;
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = l2_ctrl_state_e'('x);
                    rr_ptr_d  = 'x;
                    grant_q_d = 'x;
                    beat_d    = 'x;
                    grant_id  = 'x;
                    req_fulfilled            = 'x;
                    memory_req_valid         = 1'bx;
                    memory_req_type          = memory_operation_e'('x);
                    process_lru_counters     = 1'bx;
                    flush_mode               = 1'bx;
                    load_mode                = 1'bx;
                    set_selected_dirty_bit   = 1'bx;
                    clear_selected_dirty_bit = 1'bx;
                    clear_selected_valid_bit = 1'bx;
                    perform_write            = 1'bx;
                    finish_new_line_install  = 1'bx;
                    set_new_higher_memory_block_address           = 1'bx;
                    use_dirty_tag_for_higher_memory_block_address = 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_arbitrated_cache_controller.sv
// Directed self-checking bench for the L2 controller (2 ports, 4 words per line).
module tb_l2_arbitrated_cache_controller;
    import xentry_pkg::*;

    localparam int unsigned NP  = 2;
    localparam int unsigned WPL = 4;

    logic                          clk = 1'b0;
    logic                          reset = 1'b1;
    logic [NP-1:0]                 req_valid = '0;
    memory_operation_e [NP-1:0]    req_type;
    logic [NP-1:0]                 req_fulfilled;
    logic [0:0]                    grant_id;
    logic                          memory_req_valid;
    memory_operation_e             memory_req_type;
    logic                          memory_req_fulfilled = 1'b0;
    logic [1:0]                    beat_index;
    logic                          process_lru_counters;
    logic                          flush_mode;
    logic                          load_mode;
    logic                          set_selected_dirty_bit;
    logic                          clear_selected_dirty_bit;
    logic                          clear_selected_valid_bit;
    logic                          perform_write;
    logic                          finish_new_line_install;
    logic                          set_new_hmba;
    logic                          use_dirty_tag_hmba;
    logic                          valid_block_match = 1'b0;
    logic                          valid_dirty_bit = 1'b0;

    int checks = 0;
    int errors = 0;

    l2_arbitrated_cache_controller #(.NUM_PORTS(NP), .WORDS_PER_LINE(WPL)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_type                 (req_type),
        .req_fulfilled            (req_fulfilled),
        .grant_id                 (grant_id),
        .memory_req_valid         (memory_req_valid),
        .memory_req_type          (memory_req_type),
        .memory_req_fulfilled     (memory_req_fulfilled),
        .beat_index               (beat_index),
        .process_lru_counters     (process_lru_counters),
        .flush_mode               (flush_mode),
        .load_mode                (load_mode),
        .set_selected_dirty_bit   (set_selected_dirty_bit),
        .clear_selected_dirty_bit (clear_selected_dirty_bit),
        .clear_selected_valid_bit (clear_selected_valid_bit),
        .perform_write            (perform_write),
        .finish_new_line_install  (finish_new_line_install),
        .set_new_higher_memory_block_address           (set_new_hmba),
        .use_dirty_tag_for_higher_memory_block_address (use_dirty_tag_hmba),
        .valid_block_match        (valid_block_match),
        .valid_dirty_bit          (valid_dirty_bit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int p);
        logic [1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Fill: four beats, every beat accepted immediately.
    task automatic alloc_seq(input int gid);
        for (int b = 0; b < int'(WPL); b++) begin
            memory_req_fulfilled = 1'b1;
            #1;
            check("alloc_state", dut.state, ST_ALLOCATE);
            check("alloc_beat", beat_index, b);
            check("alloc_load_mode", load_mode, 1);
            check("alloc_mem_valid", memory_req_valid, 1);
            check("alloc_mem_type", memory_req_type, LOAD);
            check("alloc_write", perform_write, 1);
            check("alloc_finish", finish_new_line_install, (b == int'(WPL) - 1) ? 1 : 0);
            check("alloc_clr_dirty", clear_selected_dirty_bit, (b == int'(WPL) - 1) ? 1 : 0);
            check("alloc_grant", grant_id, gid);
            check("alloc_fulfilled", req_fulfilled, 0);
            cyc();
        end
        memory_req_fulfilled = 1'b0;
    endtask

    // Writeback or flush: four STORE beats.
    task automatic store_seq(input bit is_flush, input int gid);
        logic last;
        for (int b = 0; b < int'(WPL); b++) begin
            memory_req_fulfilled = 1'b1;
            last = (b == int'(WPL) - 1);
            #1;
            check("st_state", dut.state, is_flush ? ST_FLUSH : ST_WRITEBACK);
            check("st_beat", beat_index, b);
            check("st_flush_mode", flush_mode, 1);
            check("st_mem_valid", memory_req_valid, 1);
            check("st_mem_type", memory_req_type, STORE);
            check("st_clr_valid", clear_selected_valid_bit, last);
            check("st_clr_dirty", clear_selected_dirty_bit, last);
            check("st_hmba", set_new_hmba, (!is_flush && last) ? 1 : 0);
            check("st_fulfilled", req_fulfilled, (is_flush && last) ? onehot(gid) : 2'b00);
            cyc();
        end
        memory_req_fulfilled = 1'b0;
    endtask

    initial begin
        req_type = {LOAD, LOAD};
        #3;
        check("rst_state", dut.state, ST_IDLE);
        check("rst_fulfilled", req_fulfilled, 0);
        check("rst_mem_valid", memory_req_valid, 0);
        check("rst_mem_type", memory_req_type, LOAD);
        check("rst_beat", beat_index, 0);
        check("rst_grant", grant_id, 0);
        cyc();
        reset = 1'b0;

        // P0 LOAD hit
        req_valid = 2'b01; req_type[0] = LOAD; valid_block_match = 1; valid_dirty_bit = 0;
        #1;
        check("hit0_fulfilled", req_fulfilled, 2'b01);
        check("hit0_lru", process_lru_counters, 1);
        check("hit0_mem_valid", memory_req_valid, 0);
        check("hit0_write", perform_write, 0);
        cyc();

        // P1 STORE clean miss, one stalled beat, then fill
        req_valid = 2'b10; req_type[1] = STORE; valid_block_match = 0; valid_dirty_bit = 0;
        #1;
        check("miss1_grant", grant_id, 1);
        check("miss1_hmba", set_new_hmba, 1);
        check("miss1_use_dirty", use_dirty_tag_hmba, 0);
        check("miss1_fulfilled", req_fulfilled, 0);
        cyc();
        memory_req_fulfilled = 0;
        #1;
        check("stall_beat", beat_index, 0);
        check("stall_write", perform_write, 0);
        check("stall_mem_valid", memory_req_valid, 1);
        cyc();
        alloc_seq(1);
        valid_block_match = 1;
        #1;
        check("miss1_hit_fulfilled", req_fulfilled, 2'b10);
        check("miss1_hit_write", perform_write, 1);
        check("miss1_hit_set_dirty", set_selected_dirty_bit, 1);
        cyc();

        // P0 LOAD dirty miss: writeback then fill
        req_valid = 2'b01; req_type[0] = LOAD; valid_block_match = 0; valid_dirty_bit = 1;
        #1;
        check("dmiss_grant", grant_id, 0);
        check("dmiss_hmba", set_new_hmba, 1);
        check("dmiss_use_dirty", use_dirty_tag_hmba, 1);
        cyc();
        store_seq(0, 0);
        valid_dirty_bit = 0;
        alloc_seq(0);
        valid_block_match = 1;
        #1;
        check("dmiss_hit_fulfilled", req_fulfilled, 2'b01);
        cyc();

        // Both ports hitting every cycle alternate, starting from P1
        req_valid = 2'b11; req_type = {LOAD, LOAD}; valid_block_match = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_fulfilled", req_fulfilled, (i % 2 == 0) ? 2'b10 : 2'b01);
            cyc();
        end
        // P1 miss holds grant on P1 while P0 keeps requesting
        valid_block_match = 0;
        #1;
        check("rr_miss_grant", grant_id, 1);
        check("rr_miss_fulfilled", req_fulfilled, 0);
        cyc();
        alloc_seq(1);
        valid_block_match = 1;
        #1;
        check("rr_miss_done", req_fulfilled, 2'b10);
        cyc();

        // CLFLUSH dirty hit on P0
        req_valid = 2'b01; req_type[0] = CLFLUSH; valid_block_match = 1; valid_dirty_bit = 1;
        #1;
        check("cf_hmba", set_new_hmba, 1);
        check("cf_use_dirty", use_dirty_tag_hmba, 0);
        check("cf_fulfilled", req_fulfilled, 0);
        cyc();
        store_seq(1, 0);
        req_valid = 2'b00;
        #1;
        check("cf_back_idle", dut.state, ST_IDLE);

        // CLFLUSH miss on P1: complete with no array strobes
        req_valid = 2'b10; req_type[1] = CLFLUSH; valid_block_match = 0; valid_dirty_bit = 0;
        #1;
        check("cfm_fulfilled", req_fulfilled, 2'b10);
        check("cfm_clr_valid", clear_selected_valid_bit, 0);
        check("cfm_clr_dirty", clear_selected_dirty_bit, 0);
        check("cfm_write", perform_write, 0);
        check("cfm_hmba", set_new_hmba, 0);
        cyc();

        // CLFLUSH clean hit on P0: invalidate only
        req_valid = 2'b01; req_type[0] = CLFLUSH; valid_block_match = 1; valid_dirty_bit = 0;
        #1;
        check("cfc_fulfilled", req_fulfilled, 2'b01);
        check("cfc_clr_valid", clear_selected_valid_bit, 1);
        check("cfc_mem_valid", memory_req_valid, 0);
        cyc();

        // Reset during beat 2 of a fill aborts immediately
        req_valid = 2'b10; req_type[1] = LOAD; valid_block_match = 0; valid_dirty_bit = 0;
        #1;
        check("rmiss_grant", grant_id, 1);
        cyc();
        memory_req_fulfilled = 1;
        cyc();
        cyc();
        #1;
        check("rmid_beat", beat_index, 2);
        valid_block_match = 1;
        reset = 1'b1;
        #1;
        check("rmid_state", dut.state, ST_IDLE);
        check("rmid_mem_valid", memory_req_valid, 0);
        check("rmid_beat0", beat_index, 0);
        check("rmid_fulfilled", req_fulfilled, 0);
        memory_req_fulfilled = 0;
        req_valid = 2'b00;
        cyc();
        reset = 1'b0;
        #1;
        check("rpost_grant", grant_id, 0);

        // Back in service after reset
        req_valid = 2'b01; req_type[0] = LOAD; valid_block_match = 1;
        #1;
        check("rpost_hit", req_fulfilled, 2'b01);
        cyc();
        req_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
